// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command sequencer: FSM states, command-byte layout,
// error flag positions and the fill byte returned when a register read times out.
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_RD_HOLD = 3'd5,
        ST_DRAIN   = 3'd6
    } state_t;

    localparam int RW_BIT = 7;

    localparam int ERR_TIMEOUT  = 2;
    localparam int ERR_UNDERRUN = 1;
    localparam int ERR_OVERFLOW = 0;

    localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

endpackage

// File: rtl/spi_rd_timeout.sv
// Loadable down-counter guarding a register read; expire pulses in the last
// counted cycle if the read data has still not come back.
module spi_rd_timeout #(
    parameter int CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= CW'(CYCLES);
        end else if (run && count_reg != '0) begin
            count_reg <= count_reg - CW'(1);
        end
    end

    assign expire = run && (count_reg == CW'(1));

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Per-chip-select frame controller: parses the command byte, issues register
// writes/reads with address auto-increment and feeds read data to the SPI transmitter.
module spi_cmd_sequencer
    import spi_cmd_pkg::*;
#(
    parameter int MAX_BYTES_PER_CS = 8,
    parameter int ADDR_W           = 7,
    parameter int RD_TIMEOUT       = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic              tx_load,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata,
    input  logic              reg_rd_valid,
    output logic              busy,
    output logic [2:0]        err,
    input  logic              err_clr
);

    localparam int CNT_W = $clog2(MAX_BYTES_PER_CS + 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              at_limit;
    logic              tmo_expire;
    logic [2:0]        err_set;

    assign at_limit = (cnt_reg == CNT_W'(MAX_BYTES_PER_CS));
    assign busy     = (state_reg != ST_IDLE);

    spi_rd_timeout #(
        .CYCLES(RD_TIMEOUT)
    ) u_rd_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (state_reg == ST_RD_REQ),
        .run    (state_reg == ST_RD_WAIT),
        .expire (tmo_expire)
    );

    // A byte that would overflow the frame is dropped, so it never also counts as an underrun.
    always_comb begin
        err_set = '0;
        if (cs_active && rx_valid) begin
            case (state_reg)
                ST_WRITE, ST_RD_HOLD: err_set[ERR_OVERFLOW] = at_limit;
                ST_RD_REQ, ST_RD_WAIT: begin
                    err_set[ERR_OVERFLOW] = at_limit;
                    err_set[ERR_UNDERRUN] = !at_limit;
                end
                default: ;
            endcase
        end
        if (cs_active && state_reg == ST_RD_WAIT && !(rx_valid && at_limit)
            && !reg_rd_valid && tmo_expire) begin
            err_set[ERR_TIMEOUT] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            cnt_reg   <= '0;
            tx_byte   <= '0;
            tx_load   <= 1'b0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            err       <= '0;
        end else begin
            tx_load   <= 1'b0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            err       <= (err_clr ? 3'b000 : err) | err_set;

            // Chip-select release abandons the frame, including any read in flight.
            if (state_reg != ST_IDLE && !cs_active) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (cs_active) state_reg <= ST_CMD;
                    end
                    ST_CMD: begin
                        if (rx_valid) begin
                            addr_reg <= rx_byte[ADDR_W-1:0];
                            cnt_reg  <= CNT_W'(1);
                            if (rx_byte[RW_BIT]) begin
                                state_reg <= ST_WRITE;
                            end else begin
                                state_reg <= ST_RD_REQ;
                                reg_rd_en <= 1'b1;
                                reg_addr  <= rx_byte[ADDR_W-1:0];
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (rx_valid) begin
                            if (at_limit) begin
                                state_reg <= ST_DRAIN;
                            end else begin
                                cnt_reg   <= cnt_reg + CNT_W'(1);
                                reg_wr_en <= 1'b1;
                                reg_addr  <= addr_reg;
                                reg_wdata <= rx_byte;
                                addr_reg  <= addr_reg + ADDR_W'(1);
                            end
                        end
                    end
                    ST_RD_REQ: begin
                        if (rx_valid && at_limit) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            if (rx_valid) cnt_reg <= cnt_reg + CNT_W'(1);
                            state_reg <= ST_RD_WAIT;
                        end
                    end
                    ST_RD_WAIT: begin
                        if (rx_valid && at_limit) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            if (rx_valid) cnt_reg <= cnt_reg + CNT_W'(1);
                            if (reg_rd_valid) begin
                                tx_byte   <= reg_rdata;
                                tx_load   <= 1'b1;
                                addr_reg  <= addr_reg + ADDR_W'(1);
                                state_reg <= ST_RD_HOLD;
                            end else if (tmo_expire) begin
                                tx_byte   <= TIMEOUT_FILL;
                                tx_load   <= 1'b1;
                                state_reg <= ST_RD_HOLD;
                            end
                        end
                    end
                    ST_RD_HOLD: begin
                        // The dummy byte shifting out the current data also prefetches the next register.
                        if (rx_valid) begin
                            if (at_limit) begin
                                state_reg <= ST_DRAIN;
                            end else begin
                                cnt_reg   <= cnt_reg + CNT_W'(1);
                                state_reg <= ST_RD_REQ;
                                reg_rd_en <= 1'b1;
                                reg_addr  <= addr_reg;
                            end
                        end
                    end
                    ST_DRAIN: ;
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
